// File: rtl/audio_i2s_tx.sv
// I2S/TDM audio transmitter: frame FIFO plus BCK/LRCK generation from iCLK.
// Frames are latched at frame start and shifted out MSB-first with a one-BCK delay.
module audio_i2s_tx #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned SLOT_WIDTH = 24,
    parameter int unsigned BCLK_DIV   = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                           iCLK,
    input  logic                           iRST,
    input  logic [DATA_WIDTH*CHANNELS-1:0] iSample,
    input  logic                           iValid,
    output logic                           oReady,
    input  logic                           iMute,
    output logic                           oAUD_BCK,
    output logic                           oAUD_LRCK,
    output logic                           oAUD_DATA,
    output logic                           oUnderrun,
    output logic [$clog2(FIFO_DEPTH):0]    oFill
);
    localparam int unsigned FW     = DATA_WIDTH * CHANNELS;
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned OFF_W  = $clog2(SLOT_WIDTH);
    localparam int unsigned SLOT_W = $clog2(CHANNELS);

    logic [FW-1:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_fill;
    logic              r_ready;
    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_bck;
    logic              r_lrck;
    logic              r_data;
    logic              r_underrun;
    logic [OFF_W-1:0]  r_off;
    logic [SLOT_W-1:0] r_slot;
    logic [FW-1:0]     r_shift;

    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_div_wrap;
    logic              w_fall;
    logic              w_frame_start;
    logic              w_data_pos;
    logic [AW:0]       w_fill_nxt;
    logic [OFF_W-1:0]  w_off_nxt;
    logic [SLOT_W-1:0] w_slot_nxt;
    logic [FW-1:0]     w_head_ordered;

    assign w_push        = iValid && r_ready;
    assign w_empty       = (r_fill == '0);
    assign w_div_wrap    = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
    assign w_fall        = w_div_wrap && r_bck;
    assign w_frame_start = w_fall && (r_off == OFF_W'(SLOT_WIDTH - 1))
                           && (r_slot == SLOT_W'(CHANNELS - 1));
    assign w_pop         = w_frame_start && !w_empty;
    assign w_data_pos    = (w_off_nxt != '0) && (w_off_nxt <= OFF_W'(DATA_WIDTH));

    always_comb begin
        w_fill_nxt = r_fill;
        if (w_push && !w_pop) begin
            w_fill_nxt = r_fill + 1'b1;
        end else if (w_pop && !w_push) begin
            w_fill_nxt = r_fill - 1'b1;
        end
    end

    always_comb begin
        w_off_nxt  = r_off + 1'b1;
        w_slot_nxt = r_slot;
        if (r_off == OFF_W'(SLOT_WIDTH - 1)) begin
            w_off_nxt  = '0;
            w_slot_nxt = (r_slot == SLOT_W'(CHANNELS - 1)) ? '0 : r_slot + 1'b1;
        end
    end

    // Channel 0 goes to the top so one left shift walks through every channel in order.
    always_comb begin
        w_head_ordered = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_head_ordered[(CHANNELS-1-c)*DATA_WIDTH +: DATA_WIDTH] =
                r_mem[r_rptr][c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= iSample;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fill     <= '0;
            r_ready    <= 1'b1;
            r_div_cnt  <= '0;
            r_bck      <= 1'b0;
            r_lrck     <= 1'b0;
            r_data     <= 1'b0;
            r_underrun <= 1'b0;
            r_off      <= OFF_W'(SLOT_WIDTH - 1);
            r_slot     <= SLOT_W'(CHANNELS - 1);
            r_shift    <= '0;
        end else begin
            r_div_cnt  <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
            if (w_div_wrap) begin
                r_bck <= !r_bck;
            end
            r_underrun <= w_frame_start && w_empty;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_fill  <= w_fill_nxt;
            r_ready <= (w_fill_nxt != (AW+1)'(FIFO_DEPTH));
            if (w_fall) begin
                r_off  <= w_off_nxt;
                r_slot <= w_slot_nxt;
                r_lrck <= (w_slot_nxt >= SLOT_W'(CHANNELS / 2));
                if (w_frame_start) begin
                    r_shift <= (w_pop && !iMute) ? w_head_ordered : '0;
                    r_data  <= 1'b0;
                end else if (w_data_pos) begin
                    r_data  <= r_shift[FW-1];
                    r_shift <= r_shift << 1;
                end else begin
                    r_data  <= 1'b0;
                end
            end
        end
    end

    assign oReady    = r_ready;
    assign oAUD_BCK  = r_bck;
    assign oAUD_LRCK = r_lrck;
    assign oAUD_DATA = r_data;
    assign oUnderrun = r_underrun;
    assign oFill     = r_fill;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: cycle-count reference model feeding a frame scoreboard,
// with a serial monitor that reassembles transmitted frames and checks them.
module tb_audio_i2s_tx;
    localparam int DW    = 16;
    localparam int CH    = 2;
    localparam int SW    = 24;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int FW    = DW * CH;
    localparam int N     = CH * SW;
    localparam int FR    = 2 * DIV * N;

    logic                     iCLK = 1'b0;
    logic                     iRST = 1'b1;
    logic [FW-1:0]            iSample = '0;
    logic                     iValid = 1'b0;
    logic                     iMute = 1'b0;
    logic                     oReady;
    logic                     oAUD_BCK;
    logic                     oAUD_LRCK;
    logic                     oAUD_DATA;
    logic                     oUnderrun;
    logic [$clog2(DEPTH):0]   oFill;

    audio_i2s_tx #(
        .DATA_WIDTH(DW),
        .CHANNELS  (CH),
        .SLOT_WIDTH(SW),
        .BCLK_DIV  (DIV),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iSample  (iSample),
        .iValid   (iValid),
        .oReady   (oReady),
        .iMute    (iMute),
        .oAUD_BCK (oAUD_BCK),
        .oAUD_LRCK(oAUD_LRCK),
        .oAUD_DATA(oAUD_DATA),
        .oUnderrun(oUnderrun),
        .oFill    (oFill)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: everything derives from t, the number of edges since reset release.
    logic [FW-1:0] m_fifo[$];
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] m_fr;
    logic          m_push;
    int            t = 0;
    int            m_F = 0;
    int            m_pos = N - 1;
    int            n_starts = 0;
    logic          e_bck = 1'b0;
    logic          e_lrck = 1'b0;
    logic          e_under = 1'b0;
    logic          e_ready = 1'b1;
    int            e_fill = 0;

    always @(posedge iCLK) begin
        if (iRST) begin
            t = 0;
            m_pos = N - 1;
            m_fifo.delete();
            exp_q.delete();
            e_bck = 1'b0;
            e_lrck = 1'b0;
            e_under = 1'b0;
            e_fill = 0;
            e_ready = 1'b1;
        end else begin
            m_push = iValid && (m_fifo.size() < DEPTH);
            t++;
            m_F = t / (2 * DIV);
            e_under = 1'b0;
            if ((t % (2 * DIV) == 0) && ((m_F - 1) % N == 0)) begin
                n_starts++;
                if (m_fifo.size() > 0) begin
                    m_fr = m_fifo.pop_front();
                    if (iMute) m_fr = '0;
                end else begin
                    m_fr = '0;
                    e_under = 1'b1;
                end
                exp_q.push_back(m_fr);
            end
            if (m_push) m_fifo.push_back(iSample);
            e_fill = m_fifo.size();
            e_ready = (e_fill < DEPTH);
            e_bck = ((t / DIV) % 2) == 1;
            m_pos = (m_F >= 1) ? (m_F - 1) % N : N - 1;
            e_lrck = (m_F >= 1) && ((m_pos / SW) >= CH / 2);
        end
    end

    // Monitor: reassemble serial bits per frame position and score completed frames.
    logic chk_en = 1'b0;
    logic cap[N];
    logic prev_bck = 1'b0;
    logic have = 1'b0;
    int   mon_p = N - 1;

    task automatic score_frame();
        logic [FW-1:0] e;
        logic [DW-1:0] w;
        int pad;
        if (exp_q.size() == 0) begin
            chk("frame_expected", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        pad = 0;
        for (int c = 0; c < CH; c++) begin
            w = '0;
            for (int o = 1; o <= DW; o++) w = (w << 1) | DW'(cap[c*SW+o]);
            chk($sformatf("ch%0d_word", c), int'(w), int'(e[c*DW +: DW]));
            for (int o = 0; o < SW; o++) begin
                if (o == 0 || o > DW) pad += int'(cap[c*SW+o]);
            end
        end
        chk("padding_ones", pad, 0);
    endtask

    always @(posedge iCLK) begin
        #2;
        if (chk_en) begin
            chk("bck", int'(oAUD_BCK), int'(e_bck));
            chk("lrck", int'(oAUD_LRCK), int'(e_lrck));
            chk("underrun", int'(oUnderrun), int'(e_under));
            chk("ready", int'(oReady), int'(e_ready));
            chk("fill", int'(oFill), e_fill);
        end
        if (iRST) begin
            mon_p = N - 1;
            prev_bck = 1'b0;
            have = 1'b0;
        end else begin
            if (prev_bck && !oAUD_BCK) begin
                mon_p = (mon_p + 1) % N;
                if (mon_p == 0) begin
                    if (have) score_frame();
                    have = 1'b1;
                end
                cap[mon_p] = oAUD_DATA;
            end
            prev_bck = oAUD_BCK;
        end
    end

    // Holds iValid high until the model accepts the frame; caller drops iValid.
    task automatic send(input logic [FW-1:0] f);
        int n = 0;
        iSample = f;
        iValid = 1'b1;
        while (!e_ready && n < 4 * FR) begin
            @(negedge iCLK);
            n++;
        end
        if (n >= 4 * FR) chk("timeout_send", 0, 1);
        @(negedge iCLK);
    endtask

    task automatic drain();
        int n = 0;
        while (e_fill != 0 && n < 8 * FR) begin
            @(negedge iCLK);
            n++;
        end
        if (n >= 8 * FR) chk("timeout_drain", 0, 1);
    endtask

    task automatic wait_start();
        int s0 = n_starts;
        int n = 0;
        while (n_starts == s0 && n < 2 * FR) begin
            @(negedge iCLK);
            n++;
        end
        if (n >= 2 * FR) chk("timeout_start", 0, 1);
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (!(m_F >= 1 && m_pos == p) && n < 2 * FR) begin
            @(negedge iCLK);
            n++;
        end
        if (n >= 2 * FR) chk("timeout_pos", 0, 1);
    endtask

    initial begin
        logic [FW-1:0] f;
        iRST = 1'b1;
        @(negedge iCLK);
        chk_en = 1'b1;
        repeat (2) @(negedge iCLK);
        iRST = 1'b0;

        // Idle: underrun every frame, silent data
        repeat (2 * FR + 10) @(negedge iCLK);

        // Single known frame
        send({16'h8001, 16'hA5C3});
        iValid = 1'b0;
        repeat (2 * FR) @(negedge iCLK);

        // Backpressure: five frames with iValid held high
        for (int i = 0; i < 5; i++) send({16'(16'h1100 + i), 16'(16'hC0F0 + i)});
        iValid = 1'b0;
        drain();
        repeat (FR) @(negedge iCLK);

        // Mute across one frame start, then unmuted
        send({16'h7FFF, 16'h7FFF});
        send({16'h7FFF, 16'h7FFF});
        iValid = 1'b0;
        iMute = 1'b1;
        wait_start();
        iMute = 1'b0;
        drain();
        repeat (2 * FR) @(negedge iCLK);

        // Random traffic with occasional mute
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < CH; c++) f[c*DW +: DW] = DW'($urandom);
            iSample = f;
            iValid = ($urandom_range(0, 3) == 0);
            iMute = ($urandom_range(0, 7) == 0);
            @(negedge iCLK);
        end
        iValid = 1'b0;
        iMute = 1'b0;
        drain();
        repeat (2 * FR) @(negedge iCLK);

        // Reset mid-frame with frames buffered
        for (int i = 0; i < 3; i++) send({16'(16'h5A00 + i), 16'(16'h3C00 + i)});
        iValid = 1'b0;
        wait_pos(10);
        iRST = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0;
        repeat (3 * FR) @(negedge iCLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Parametrised I2S/TDM audio transmitter for the audio CODEC DAC path. It accepts parallel multi-channel sample frames over a valid/ready handshake and buffers them in a frame FIFO. It derives the bit clock and frame clock from the single system clock and serialises the frames MSB-first with the I2S one-bit delay. It supports mute and reports underrun, and sits between any sample source (tone generator, SD/SRAM playback) and the CODEC's BCLK/DACLRCK/DACDAT pins.

## Interface
- DATA_WIDTH, 16: bits per sample.
- CHANNELS, 2: channels per frame; even, ≥2 (2 = standard I2S, >2 = TDM-style 50% frame clock).
- SLOT_WIDTH, 24: BCLK periods per channel slot; must be > DATA_WIDTH.
- BCLK_DIV, 4: iCLK cycles per BCLK half-period; ≥1.
- FIFO_DEPTH, 4: frames buffered; power of 2, ≥2.
- iCLK  in  1  system/audio clock; the only clock.
- iRST  in  1  reset, synchronous, active-high.
- iSample  in  DATA_WIDTH*CHANNELS  frame; channel c at [c*DATA_WIDTH +: DATA_WIDTH], channel 0 = left, two's complement.
- iValid  in  1  frame valid.
- oReady  out  1  FIFO can accept a frame.
- iMute  in  1  transmit zeros, still consuming frames.
- oAUD_BCK  out  1  bit clock.
- oAUD_LRCK  out  1  frame/word clock.
- oAUD_DATA  out  1  serial data.
- oUnderrun  out  1  one-cycle pulse: frame start with FIFO empty.
- oFill  out  $clog2(FIFO_DEPTH)+1  frames currently held.

## Operation
- Push: iValid && oReady at a rising iCLK edge writes iSample into the FIFO. oReady = !full, registered from the fill count. Data offered while oReady=0 is ignored.
- Divider: div_cnt runs 0..BCLK_DIV-1. When it wraps, oAUD_BCK toggles. A toggle 1→0 is a "fall event".
- Frame position p runs 0..N-1, where N = CHANNELS*SLOT_WIDTH. p advances on each fall event and wraps N-1→0.
- Frame start (fall event with p wrapping to 0):
  - FIFO non-empty: pop the head into the frame shift register. If iMute=1 on that cycle, load zeros instead; the pop still occurs.
  - FIFO empty: load zeros and pulse oUnderrun for 1 cycle.
- Outputs at a fall event for new position p, with slot s = p / SLOT_WIDTH and offset o = p % SLOT_WIDTH:
  - oAUD_LRCK = 0 if s < CHANNELS/2, else 1.
  - oAUD_DATA = bit (DATA_WIDTH-o) of channel s when 1 ≤ o ≤ DATA_WIDTH, else 0. This gives MSB one BCLK after the slot boundary (I2S delay), then zero padding.
  - Both outputs change only on fall events, so they are stable across the BCK rising edge.
- Push and pop in the same cycle: both take effect and oFill is unchanged. Push while full is impossible (oReady=0). A pop on the cycle the FIFO becomes full is honoured, and oReady rises the following cycle.
- Frame content is latched at frame start. Mid-frame FIFO activity and mid-frame iMute changes do not alter the frame in flight.

## Timing
- Reset values: oAUD_BCK=0, oAUD_LRCK=0, oAUD_DATA=0, oUnderrun=0, oFill=0, oReady=1 (on the cycle after iRST is sampled high). FIFO pointers cleared; div_cnt=0; p=N-1.
- Reset asserted mid-frame: all state returns to reset values on the next edge. Buffered frames are discarded, and no underrun pulse is produced during reset.
- After iRST deasserts (first cycle = cycle 1):
  - BCK rises at the end of cycle BCLK_DIV.
  - First fall event at cycle 2*BCLK_DIV: p=0, first frame start.
- Frame period = 2*BCLK_DIV*N iCLK cycles. Defaults: 384 cycles, i.e. 48 kHz at 18.432 MHz.
- Latency: a frame pushed into an empty FIFO before a frame start is popped at that start. Its channel 0 MSB appears 2*BCLK_DIV cycles later (p=1).
- oFill and oReady update one cycle after the push/pop edge.

## Test plan
- Reset/idle: hold iRST 3 cycles, no pushes → all outputs at reset values; first fall event at cycle 8 (defaults); oUnderrun pulses every 384 cycles; oAUD_DATA stays 0.
- Single frame: push ch0=16'hA5C3, ch1=16'h8001 → at p=1..16, DATA = A5C3 MSB-first with LRCK=0; at p=25..40, DATA = 8001 with LRCK=1; all padding bits 0.
- Backpressure: push 5 frames back-to-back with iValid held high → oReady drops after the 4th accepted (oFill=4); the 5th is accepted only after the next frame start pops (oFill 4→3→4).
- Mute: 2 frames of 16'h7FFF buffered; iMute=1 across the first frame start → first frame all zeros, oFill decrements; iMute=0 → second frame transmits 7FFF.
- TDM: CHANNELS=4, SLOT_WIDTH=20, BCLK_DIV=1 → frame 160 cycles; LRCK low for slots 0-1, high for slots 2-3; each channel MSB at slot offset 1.
- Reset mid-frame: assert iRST at p=10 with 3 frames buffered → oFill=0 and outputs at reset values next cycle; after release, first frame start underruns.
